digit_serial_adder: RTL and testbench



---
 rtl/digit_serial_adder.sv | 103 ++++++++++
 tb/tb_digit_serial_adder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract: one DIGIT-wide ripple slice reused for WIDTH/DIGIT cycles,
// with a registered carry between digits and a start/done handshake.
module digit_serial_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic             r_cmsb;
    logic [CW-1:0]    r_cnt;

    logic [DIGIT:0]       w_dsum;
    logic                 w_cmsb;
    logic [WIDTH+DIGIT-1:0] w_res_cat;
    logic [WIDTH+DIGIT-1:0] w_res_shift;
    logic                 w_accept;

    assign w_dsum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, r_carry};
    // Carry into the digit MSB recovered from the MSB sum bit and its two operand bits.
    assign w_cmsb      = w_dsum[DIGIT-1] ^ r_a[DIGIT-1] ^ r_b[DIGIT-1];
    assign w_res_cat   = {w_dsum[DIGIT-1:0], r_res};
    assign w_res_shift = w_res_cat >> DIGIT;
    assign w_accept    = start && (r_state == StIdle || r_state == StDone);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cmsb  <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_state <= StIdle;
                end
                StRun: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_res   <= w_res_shift[WIDTH-1:0];
                    r_carry <= w_dsum[DIGIT];
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CW'(N - 1)) begin
                        r_cmsb  <= w_cmsb;
                        busy    <= 1'b0;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    done    <= 1'b1;
                    sum     <= r_res;
                    cout    <= r_carry;
                    ovf     <= r_carry ^ r_cmsb;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
            // A new request is taken in IDLE or in the DONE cycle, giving back-to-back issue.
            if (w_accept) begin
                r_a     <= a;
                r_b     <= sub ? ~b : b;
                r_carry <= sub ? 1'b1 : cin;
                r_cnt   <= '0;
                busy    <= 1'b1;
                r_state <= StRun;
            end
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: three instances (DIGIT = 16, 4, 1 digits of WIDTH 16)
// driven in lockstep, checked against a table and an arithmetic reference model.
module tb_digit_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;

    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  cout_v;
    logic [2:0]  ovf_v;
    logic [15:0] sum_v [3];

    int n_checks = 0;
    int n_fail   = 0;
    int n_of [3];

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0])
    );
    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1])
    );
    digit_serial_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2])
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
    } op_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mcin, input logic msub);
        int ua, ub, sa, sb, full, sres;
        logic [31:0] fv;
        logic        o;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (msub) begin
            full = ua + 65536 - ub;
            sres = sa - sb;
        end else begin
            full = ua + ub + int'(mcin);
            sres = sa + sb + int'(mcin);
        end
        o  = (sres > 32767) || (sres < -32768);
        fv = full;
        return {o, fv[16], fv[15:0]};
    endfunction

    // Issues one request, then checks busy/done timing and results on every instance.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tcin,
                         input logic tsub, input logic [15:0] es, input logic ec,
                         input logic eo);
        a = ta; b = tb_; cin = tcin; sub = tsub; start = 1'b1;
        for (int j = 0; j <= 18; j++) begin
            @(negedge clk);
            if (j == 0) begin
                start = 1'b0;
                a = 16'(a + 16'h1111);
                b = ~b;
                cin = ~cin;
                sub = ~sub;
            end
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("busy i%0d j%0d", i, j), 32'(busy_v[i]), 32'(j < n_of[i]));
                chk($sformatf("done i%0d j%0d", i, j), 32'(done_v[i]), 32'(j == n_of[i] + 1));
                if (j == n_of[i] + 1 || j == 18) begin
                    chk($sformatf("sum i%0d j%0d", i, j), 32'(sum_v[i]), 32'(es));
                    chk($sformatf("cout i%0d j%0d", i, j), 32'(cout_v[i]), 32'(ec));
                    chk($sformatf("ovf i%0d j%0d", i, j), 32'(ovf_v[i]), 32'(eo));
                end
            end
        end
    endtask

    vec_t        vecs [6];
    op_t         ops [22];
    logic [17:0] r;

    initial begin
        n_of[0] = 16; n_of[1] = 4; n_of[2] = 1;
        vecs[0] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'hABCD, 16'h0000, 1'b1, 1'b1, 16'hABCD, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("idle i%0d c%0d", i, c),
                    {11'd0, busy_v[i], done_v[i], cout_v[i], ovf_v[i], sum_v[i]}, 32'd0);
            end
        end

        for (int v = 0; v < 6; v++) begin
            do_op(vecs[v].a, vecs[v].b, vecs[v].cin, vecs[v].sub,
                  vecs[v].exp_sum, vecs[v].exp_cout, vecs[v].exp_ovf);
        end

        // Start held high: DIGIT=4 instance accepts at edge 0 and every 5th edge after.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e < 22; e++) begin
            ops[e] = '{16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom)};
        end
        a = ops[0].a; b = ops[0].b; cin = ops[0].cin; sub = ops[0].sub; start = 1'b1;
        for (int e = 0; e <= 20; e++) begin
            @(negedge clk);
            chk($sformatf("b2b busy e%0d", e), 32'(busy_v[1]), 32'((e % 5) != 4));
            chk($sformatf("b2b done e%0d", e), 32'(done_v[1]), 32'(e > 0 && (e % 5) == 0));
            if (e > 0 && (e % 5) == 0) begin
                r = model(ops[e-5].a, ops[e-5].b, ops[e-5].cin, ops[e-5].sub);
                chk($sformatf("b2b res e%0d", e), {14'd0, ovf_v[1], cout_v[1], sum_v[1]},
                    {14'd0, r});
            end
            a = ops[e+1].a; b = ops[e+1].b; cin = ops[e+1].cin; sub = ops[e+1].sub;
        end
        start = 1'b0;
        repeat (25) @(negedge clk);

        // Reset on the second RUN edge aborts the operation everywhere.
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst outs i%0d", i),
                {11'd0, busy_v[i], done_v[i], cout_v[i], ovf_v[i], sum_v[i]}, 32'd0);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("rst nodone i%0d c%0d", i, c), 32'(done_v[i]), 32'd0);
            end
        end
        do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            logic [15:0] ra, rb;
            logic        rc, rs;
            ra = 16'($urandom);
            rb = (t % 8 == 0) ? 16'h0000 : 16'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            r  = model(ra, rb, rc, rs);
            do_op(ra, rb, rc, rs, r[15:0], r[16], r[17]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
